// File: rtl/mode_seq_pkg.sv
// Shared types and constants for the round-robin mode sequencer arbiter.
package mode_seq_pkg;

  localparam logic [1:0] PHASE_IDLE    = 2'd0;
  localparam logic [1:0] PHASE_GRANT   = 2'd1;
  localparam logic [1:0] PHASE_RUN     = 2'd2;
  localparam logic [1:0] PHASE_RELEASE = 2'd3;

  localparam int TIMEOUT_CYCLES_DEFAULT = 16;

  // Fully encoded: every 2-bit value is a legal, reachable state.
  typedef enum logic [1:0] {
    IDLE    = PHASE_IDLE,
    GRANT   = PHASE_GRANT,
    RUN     = PHASE_RUN,
    RELEASE = PHASE_RELEASE
  } state_t;

endpackage

// File: rtl/mode_seq_arbiter_rr_pick.sv
// Combinational round-robin selector: first asserted req searching from ptr+1 modulo NUM_REQ.
module rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               valid,
  output logic [ID_W-1:0]    idx
);

  int unsigned j;

  // Walk from the farthest candidate to the nearest so the nearest match wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    j     = 0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      j = (int'(ptr) + i) % NUM_REQ;
      if (req[j]) begin
        valid = 1'b1;
        idx   = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/mode_seq_arbiter.sv
// Round-robin owner of a 4-phase mode sequencer; req-to-gnt latency 1 cycle, one dead IDLE cycle between owners.
// Optional RUN watchdog enabled by defining MODE_SEQ_TIMEOUT_EN.
module mode_seq_arbiter
  import mode_seq_pkg::*;
#(
  parameter  int NUM_REQ        = 4,
  parameter  int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  localparam int ID_W           = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done_in,
  output logic [NUM_REQ-1:0] gnt,
  output logic               busy,
  output logic [1:0]         phase_out,
  output logic [ID_W-1:0]    owner_id,
  output logic               timeout_err
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("mode_seq_arbiter: unsupported NUM_REQ or TIMEOUT_CYCLES");
  end

  state_t            state, state_nxt;
  logic [ID_W-1:0]   ptr, ptr_nxt, owner_nxt;
  logic              pick_vld;
  logic [ID_W-1:0]   pick_idx;
  logic              run_exit;
  logic              wd_hit;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  // Completion wins over abort when both arrive together; both lead to one RELEASE.
  assign run_exit = done_in || !req[owner_id];

`ifdef MODE_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] wd_cnt;

  assign wd_hit = (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == GRANT)
        wd_cnt <= '0;
      else if (state == RUN)
        wd_cnt <= wd_cnt + CNT_W'(1);
      timeout_err <= (state == RUN) && !run_exit && wd_hit;
    end
  end
`else
  assign wd_hit      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner_id <= '0;
      ptr      <= ID_W'(NUM_REQ - 1);
    end else begin
      state    <= state_nxt;
      owner_id <= owner_nxt;
      ptr      <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner_id;
    ptr_nxt   = ptr;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          owner_nxt = pick_idx;
          state_nxt = GRANT;
        end
      end
      GRANT:   state_nxt = RUN;
      RUN: begin
        if (run_exit || wd_hit)
          state_nxt = RELEASE;
      end
      RELEASE: begin
        ptr_nxt   = owner_id;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt  = '0;
    busy = 1'b0;
    case (state)
      GRANT, RUN: begin
        gnt  = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_id;
        busy = 1'b1;
      end
      RELEASE: busy = 1'b1;
      default: begin
        gnt  = '0;
        busy = 1'b0;
      end
    endcase
  end

  assign phase_out = state;

endmodule
